// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue
//   Instruction fetch queue between the instruction memory front end and decode.
//   It captures {pc, inst} pairs from the fetch side and hands them to decode in
//   program order. It absorbs decode back-pressure, and a redirect flush
//   discards everything that is queued.
//
// Ports
//   clk        in   1                clock, rising edge
//   rst_n      in   1                synchronous active-low reset
//   flush      in   1                redirect: discard all entries
//   enq_valid  in   1                fetch side offers {enq_pc, enq_inst}
//   enq_pc     in   XLEN             pc of offered instruction
//   enq_inst   in   XLEN             offered instruction word
//   enq_ready  out  1                queue accepts an entry this cycle
//   deq_valid  out  1                head entry valid for decode
//   deq_pc     out  XLEN             pc of head entry (0 when empty)
//   deq_inst   out  XLEN             instruction of head entry (0 when empty)
//   deq_ready  in   1                decode consumes head entry this cycle
//   count      out  $clog2(DEPTH)+1  occupied entries
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The enq side fires on enq_valid && enq_ready. The deq side fires on
// deq_valid && deq_ready && !flush. Neither valid nor ready depends
// combinationally on its own partner signal's ready/valid. If enq_valid is high
// while enq_ready is low, the offer is dropped, and the fetch side is expected
// to hold it.
module fetch_inst_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_inst,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_inst,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Storage is not reset; contents of unoccupied slots are don't-care.
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    // Pointers carry one extra wrap bit so that full and empty can be
    // told apart when the index bits match.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic empty;
    logic full;
    logic enq_fire;
    logic deq_fire;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // No full-bypass: a deq in the same cycle does not open a slot for enq.
    assign enq_ready = !full && !flush;
    assign deq_valid = !empty;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready && !flush;

    // DEPTH is a power of two, so plain increment wraps the index and
    // toggles the wrap bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // A write during reset is harmless: the pointers are cleared on the same
    // edge, so the entry is never visible.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem[wr_ptr[AW-1:0]]   <= enq_pc;
            inst_mem[wr_ptr[AW-1:0]] <= enq_inst;
        end
    end

    // The head data is forced to zero when the queue is empty, so decode never
    // sees stale storage contents.
    assign deq_pc   = deq_valid ? pc_mem[rd_ptr[AW-1:0]]   : '0;
    assign deq_inst = deq_valid ? inst_mem[rd_ptr[AW-1:0]] : '0;

    assign count = wr_ptr - rd_ptr;

endmodule
